// File: rtl/radar_pkg.sv
// Shared types and constants for the radar sweep datapath.
// The display stage reuses CYCLES_PER_CM and MAX_CM for its own scaling.
package radar_pkg;

  // Ranger measurement sequence.
  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_HI,
    MEAS,
    DONE
  } ranger_state_e;

  // Echo-high cycles of clk_100MHz per centimetre.
  localparam int unsigned CYCLES_PER_CM  = 5800;
  // Saturation / timeout distance in centimetres.
  localparam int unsigned MAX_CM         = 400;
  // Trigger pulse width: 10 us at 100 MHz.
  localparam int unsigned TRIG_CYCLES    = 1000;
  // Longest wait for the echo rising edge: 25 ms at 100 MHz.
  localparam int unsigned WAIT_HI_CYCLES = 2_500_000;

  // Counter widths.
  localparam int unsigned SUB_W  = 13;
  localparam int unsigned CM_W   = 9;
  localparam int unsigned WAIT_W = 22;

endpackage

// File: rtl/echo_sync.sv
// Two-flop synchronizer bringing the asynchronous HC-SR04 echo into the
// clk_100MHz domain. Both flops clear on start.
module echo_sync (
  input  logic clk_100MHz,
  input  logic start,
  input  logic echo,
  output logic echo_s
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  // Next values: shift the pin through the two stages.
  always_comb begin
    sync1_d = echo;
    sync2_d = sync1_q;
  end

  // Synchronizer stages with synchronous clear.
  // NOTE: non-blocking assignments here so both stages sample the old values
  // on the same edge; blocking would collapse the chain into one flop.
  always_ff @(posedge clk_100MHz) begin
    if (start) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign echo_s = sync2_q;

endmodule

// File: rtl/hcsr04_ranger.sv
// HC-SR04 ultrasonic ranging front-end. On a one-cycle meas_req it drives a
// trigger pulse, times the echo-high interval with a per-centimetre
// sub-counter and emits one registered distance sample with a valid strobe.
// Optional feature macro: RANGER_FILTER_EN (two-tap average of good samples).
module hcsr04_ranger
  import radar_pkg::*;
#(
  parameter int unsigned CM_CYCLES  = CYCLES_PER_CM,
  parameter int unsigned TRIG_LEN   = TRIG_CYCLES,
  parameter int unsigned CM_LIMIT   = MAX_CM,
  parameter int unsigned WAIT_LIMIT = WAIT_HI_CYCLES
) (
  input  logic            clk_100MHz,
  input  logic            start,
  input  logic            meas_req,
  input  logic            echo,
  output logic            trigger,
  output logic            busy,
  output logic            dist_valid,
  output logic [CM_W-1:0] dist_cm,
  output logic            dist_timeout
);

  logic echo_s;

  echo_sync u_echo_sync (
    .clk_100MHz (clk_100MHz),
    .start      (start),
    .echo       (echo),
    .echo_s     (echo_s)
  );

  ranger_state_e     state_q, state_d;
  logic [SUB_W-1:0]  sub_cnt_q, sub_cnt_d;
  logic [CM_W-1:0]   cm_cnt_q, cm_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              trigger_q, trigger_d;
  logic              busy_q, busy_d;
  logic              dist_valid_q, dist_valid_d;
  logic [CM_W-1:0]   dist_cm_q, dist_cm_d;
  logic              dist_timeout_q, dist_timeout_d;
  logic              done_to;

`ifdef RANGER_FILTER_EN
  logic [CM_W-1:0]   last_good_q, last_good_d;
  logic              have_good_q, have_good_d;
  logic [CM_W:0]     avg_sum;
`endif

  // Next-state, counters and the timeout flag of the sample being closed.
  // NOTE: every signal gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    sub_cnt_d  = sub_cnt_q;
    cm_cnt_d   = cm_cnt_q;
    wait_cnt_d = wait_cnt_q;
    done_to    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (meas_req) begin
          state_d    = TRIG;
          sub_cnt_d  = '0;
          cm_cnt_d   = '0;
          wait_cnt_d = '0;
        end
      end
      TRIG: begin
        // wait_cnt doubles as the trigger width counter; cleared on exit.
        if (wait_cnt_q == WAIT_W'(TRIG_LEN - 1)) begin
          state_d    = WAIT_HI;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      WAIT_HI: begin
        if (echo_s) begin
          // The rising-edge cycle is already echo-high time, so it counts
          // as the first sub-count (CM_CYCLES is always well above 1).
          state_d   = MEAS;
          sub_cnt_d = SUB_W'(1);
        end else if (wait_cnt_q == WAIT_W'(WAIT_LIMIT - 1)) begin
          state_d = DONE;
          done_to = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      MEAS: begin
        if (!echo_s) begin
          state_d = DONE;
        end else if (sub_cnt_q == SUB_W'(CM_CYCLES - 1)) begin
          sub_cnt_d = '0;
          if (cm_cnt_q == CM_W'(CM_LIMIT - 1)) begin
            state_d  = DONE;
            done_to  = 1'b1;
            cm_cnt_d = CM_W'(CM_LIMIT);
          end else begin
            cm_cnt_d = cm_cnt_q + 1'b1;
          end
        end else begin
          sub_cnt_d = sub_cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs, decoded from the next state so they line up with it.
  always_comb begin
    trigger_d      = (state_d == TRIG);
    busy_d         = (state_d != IDLE);
    dist_valid_d   = (state_d == DONE);
    dist_cm_d      = dist_cm_q;
    dist_timeout_d = dist_timeout_q;
`ifdef RANGER_FILTER_EN
    last_good_d    = last_good_q;
    have_good_d    = have_good_q;
    avg_sum        = {1'b0, cm_cnt_d} + {1'b0, last_good_q};
`endif
    if (state_d == DONE) begin
      dist_timeout_d = done_to;
      if (done_to) begin
        dist_cm_d = CM_W'(CM_LIMIT);
      end else begin
`ifdef RANGER_FILTER_EN
        dist_cm_d   = have_good_q ? avg_sum[CM_W:1] : cm_cnt_d;
        last_good_d = cm_cnt_d;
        have_good_d = 1'b1;
`else
        dist_cm_d   = cm_cnt_d;
`endif
      end
    end
  end

  // Control state: start aborts any measurement on the next edge.
  always_ff @(posedge clk_100MHz) begin
    if (start) begin
      state_q      <= IDLE;
      sub_cnt_q    <= '0;
      cm_cnt_q     <= '0;
      wait_cnt_q   <= '0;
      trigger_q    <= 1'b0;
      busy_q       <= 1'b0;
      dist_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sub_cnt_q    <= sub_cnt_d;
      cm_cnt_q     <= cm_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      trigger_q    <= trigger_d;
      busy_q       <= busy_d;
      dist_valid_q <= dist_valid_d;
    end
  end

  // Sample registers: start clears them only while idle, so an abort
  // mid-measurement keeps the last published distance on the display.
  always_ff @(posedge clk_100MHz) begin
    if (start) begin
      if (state_q == IDLE) begin
        dist_cm_q      <= '0;
        dist_timeout_q <= 1'b0;
`ifdef RANGER_FILTER_EN
        last_good_q    <= '0;
        have_good_q    <= 1'b0;
`endif
      end
    end else begin
      dist_cm_q      <= dist_cm_d;
      dist_timeout_q <= dist_timeout_d;
`ifdef RANGER_FILTER_EN
      last_good_q    <= last_good_d;
      have_good_q    <= have_good_d;
`endif
    end
  end

  assign trigger      = trigger_q;
  assign busy         = busy_q;
  assign dist_valid   = dist_valid_q;
  assign dist_cm      = dist_cm_q;
  assign dist_timeout = dist_timeout_q;

endmodule

// File: tb/tb_hcsr04_ranger.sv
// Directed bench for hcsr04_ranger. Timing constants are scaled down
// (20 cycles/cm, 10-cycle trigger, 40 cm limit, 300-cycle echo wait) so the
// whole sequence stays short; the structure of every check is unchanged.
module tb_hcsr04_ranger;

  localparam int C = 20;
  localparam int T = 10;
  localparam int M = 40;
  localparam int W = 300;

  logic       clk_100MHz = 1'b0;
  logic       start;
  logic       meas_req;
  logic       echo;
  logic       trigger;
  logic       busy;
  logic       dist_valid;
  logic [8:0] dist_cm;
  logic       dist_timeout;

  int total = 0;
  int bad = 0;
  int valid_cnt = 0;

  // Reference state for the optional averaging filter.
  int  m_last = 0;
  bit  m_have = 0;

  hcsr04_ranger #(
    .CM_CYCLES  (C),
    .TRIG_LEN   (T),
    .CM_LIMIT   (M),
    .WAIT_LIMIT (W)
  ) dut (
    .clk_100MHz   (clk_100MHz),
    .start        (start),
    .meas_req     (meas_req),
    .echo         (echo),
    .trigger      (trigger),
    .busy         (busy),
    .dist_valid   (dist_valid),
    .dist_cm      (dist_cm),
    .dist_timeout (dist_timeout)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  // Count every valid strobe, sampled mid-cycle.
  always @(negedge clk_100MHz) begin
    if (dist_valid === 1'b1) valid_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_100MHz);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected published distance for a raw floored count.
  function automatic int model(input int raw, input bit to);
    int r;
    r = raw;
    if (to) return M;
`ifdef RANGER_FILTER_EN
    if (m_have) r = (raw + m_last) / 2;
    m_last = raw;
    m_have = 1'b1;
`endif
    return r;
  endfunction

  // Waits (bounded) for the trigger pulse to end.
  task automatic wait_trig_low();
    int k;
    k = 0;
    while (trigger === 1'b1 && k < T + 5) begin
      tick();
      k++;
    end
    check("trig_ends", trigger, 0);
  endtask

  // One full measurement with echo high for h cycles; ends back in IDLE
  // with the valid edge just observed.
  task automatic run_meas(input int h);
    int k;
    meas_req = 1'b1;
    tick();
    meas_req = 1'b0;
    wait_trig_low();
    echo = 1'b1;
    repeat (h) tick();
    echo = 1'b0;
    k = 0;
    while (dist_valid !== 1'b1 && k < 10) begin
      tick();
      k++;
    end
    check("meas_valid", dist_valid, 1);
  endtask

  initial begin
    int k;
    int e5;
    int v0;

    // Reset
    start = 1'b1;
    meas_req = 1'b0;
    echo = 1'b0;
    repeat (3) tick();
    start = 1'b0;
    tick();
    check("rst_trigger", trigger, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", dist_valid, 0);
    check("rst_cm", dist_cm, 0);
    check("rst_timeout", dist_timeout, 0);

    // Trigger width and 10 cm measurement with exact latency
    meas_req = 1'b1;
    tick();
    meas_req = 1'b0;
    check("trig_rise", trigger, 1);
    check("busy_trig", busy, 1);
    k = 1;
    while (k < T + 20) begin
      tick();
      if (trigger !== 1'b1) break;
      k++;
    end
    check("trig_width", k, T);
    check("busy_wait_hi", busy, 1);
    echo = 1'b1;
    repeat (10 * C) tick();
    echo = 1'b0;
    tick();
    tick();
    check("valid_early", dist_valid, 0);
    tick();
    check("valid_3cyc", dist_valid, 1);
    check("cm_10", dist_cm, model(10, 1'b0));
    check("to_10", dist_timeout, 0);
    tick();
    check("valid_1cyc", dist_valid, 0);
    check("busy_fall", busy, 0);
    check("valid_once", valid_cnt, 1);

    // 20 cm (averaged against 10 when the filter is built in)
    run_meas(20 * C);
    check("cm_20", dist_cm, model(20, 1'b0));
    tick();

    // Floor boundaries
    run_meas(C - 1);
    check("cm_floor0", dist_cm, model(0, 1'b0));
    tick();
    run_meas(C);
    check("cm_floor1", dist_cm, model(1, 1'b0));
    tick();
    run_meas(3 * C + 7);
    check("cm_floor3", dist_cm, model(3, 1'b0));
    check("to_floor3", dist_timeout, 0);
    tick();

    // No echo: timeout exactly W cycles after entering WAIT_HI
    meas_req = 1'b1;
    tick();
    meas_req = 1'b0;
    wait_trig_low();
    k = 0;
    while (dist_valid !== 1'b1 && k < W + 50) begin
      tick();
      k++;
    end
    check("noecho_latency", k, W);
    check("noecho_cm", dist_cm, model(0, 1'b1));
    check("noecho_to", dist_timeout, 1);
    tick();

    // Echo stuck high: saturates after M*C echo cycles
    meas_req = 1'b1;
    tick();
    meas_req = 1'b0;
    wait_trig_low();
    echo = 1'b1;
    k = 0;
    while (dist_valid !== 1'b1 && k < M * C + 50) begin
      tick();
      k++;
    end
    check("sat_latency", k, M * C + 2);
    check("sat_cm", dist_cm, model(0, 1'b1));
    check("sat_to", dist_timeout, 1);
    echo = 1'b0;
    repeat (4) tick();

    // Abort mid-measurement keeps the last sample
    run_meas(5 * C);
    e5 = model(5, 1'b0);
    check("cm_5", dist_cm, e5);
    tick();
    meas_req = 1'b1;
    tick();
    meas_req = 1'b0;
    wait_trig_low();
    echo = 1'b1;
    repeat (100) tick();
    v0 = valid_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("abort_trigger", trigger, 0);
    check("abort_busy", busy, 0);
    check("abort_valid", dist_valid, 0);
    check("abort_cm_held", dist_cm, e5);
    check("abort_to_held", dist_timeout, 0);
    repeat (30) tick();
    echo = 1'b0;
    repeat (10) tick();
    check("abort_no_valid", valid_cnt, v0);
    check("abort_idle", busy, 0);

    // start and meas_req together while idle: start wins
    start = 1'b1;
    meas_req = 1'b1;
    tick();
    start = 1'b0;
    meas_req = 1'b0;
    check("startreq_busy", busy, 0);
    check("startreq_trigger", trigger, 0);
    check("startreq_cm_clr", dist_cm, 0);
    m_last = 0;
    m_have = 1'b0;
    tick();
    check("startreq_not_queued", busy, 0);

    // Repeated meas_req while busy is ignored
    v0 = valid_cnt;
    meas_req = 1'b1;
    tick();
    meas_req = 1'b0;
    repeat (3) tick();
    meas_req = 1'b1;
    tick();
    meas_req = 1'b0;
    wait_trig_low();
    meas_req = 1'b1;
    tick();
    meas_req = 1'b0;
    echo = 1'b1;
    repeat (C) tick();
    meas_req = 1'b1;
    tick();
    meas_req = 1'b0;
    repeat (2 * C - 1) tick();
    echo = 1'b0;
    k = 0;
    while (dist_valid !== 1'b1 && k < 10) begin
      tick();
      k++;
    end
    check("rep_valid", dist_valid, 1);
    check("rep_cm", dist_cm, model(3, 1'b0));
    repeat (20) tick();
    check("rep_one_valid", valid_cnt, v0 + 1);
    check("rep_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hcsr04_ranger.md
# hcsr04_ranger

Ultrasonic ranging front-end for the radar sweep. It accepts a one-cycle measurement request from the servo/sweep sequencer at each angle step and drives the HC-SR04 trigger. It then times the echo pulse and emits one registered distance sample in centimetres, with a valid strobe, to the display and LED stages. Distance conversion is incremental (a sub-counter per centimetre), so no divider is needed.

## Interface
- CYCLES_PER_CM, 5800: clk_100MHz cycles of echo-high per cm.
- TRIG_CYCLES, 1000: trigger pulse width in cycles (10 us).
- MAX_CM, 400: saturation and timeout distance.
- WAIT_HI_CYCLES, 2_500_000: maximum wait for the echo rising edge (25 ms).
- clk_100MHz  in  1: sole clock, 100 MHz.
- start  in  1: reset, synchronous, active-high.
- meas_req  in  1: single-cycle request to start one measurement.
- echo  in  1: HC-SR04 echo, asynchronous.
- trigger  out  1: HC-SR04 trigger.
- busy  out  1: high in every state except IDLE.
- dist_valid  out  1: one-cycle strobe when a new sample is available.
- dist_cm  out  9: distance sample, held between strobes.
- dist_timeout  out  1: qualifies the current dist_cm as a no-echo or over-range result; held.

## Operation
- echo passes through a 2-flop synchronizer to produce echo_s. All FSM decisions use echo_s only.
- IDLE:
  - meas_req=1 moves to TRIG and clears sub_cnt, cm_cnt and wait_cnt.
  - meas_req is ignored in every other state. It is not queued.
- TRIG: trigger=1 for exactly TRIG_CYCLES cycles, then trigger=0 and the FSM moves to WAIT_HI.
- WAIT_HI:
  - echo_s=1 moves to MEAS.
  - Otherwise wait_cnt increments. When wait_cnt reaches WAIT_HI_CYCLES-1, the FSM moves to DONE with the timeout flag set.
- MEAS, on each cycle with echo_s=1:
  - When sub_cnt equals CYCLES_PER_CM-1, sub_cnt wraps to 0 and cm_cnt increments. Otherwise sub_cnt increments.
  - When cm_cnt would reach MAX_CM, the FSM moves to DONE with the timeout flag set.
- MEAS, echo_s=0: moves to DONE with the timeout flag clear.
- DONE, lasts exactly one cycle, then IDLE:
  - dist_valid=1.
  - dist_cm gets cm_cnt, or MAX_CM if the timeout flag is set.
  - dist_timeout gets the timeout flag.
- Arithmetic:
  - The result is floored, i.e. floor(echo-high cycles / CYCLES_PER_CM).
  - sub_cnt is 13 bits, cm_cnt is 9 bits, wait_cnt is 22 bits. No counter ever wraps past its limit.
- start is checked first every cycle and overrides everything. A start pulse mid-measurement:
  - aborts the measurement and goes to IDLE;
  - forces trigger=0 on the next edge;
  - produces no dist_valid.
- start and meas_req in the same cycle: start wins and the FSM stays in IDLE.
- echo already high on entry to WAIT_HI (a stale pulse) counts as a rising edge. The sequencer spaces requests at 20 ms or more.

## Timing
- Reset values: state IDLE; trigger=0, busy=0, dist_valid=0, dist_cm=0, dist_timeout=0; synchronizer flops 0.
- meas_req sampled at edge N:
  - trigger=1 and busy=1 from N+1 through N+TRIG_CYCLES.
  - trigger=0 at N+TRIG_CYCLES+1.
- Echo falling at the pin lands in echo_s 2 cycles later. MEAS sees echo_s=0 at that edge. dist_valid is high on the following cycle, i.e. 3 cycles after the pin edge.
- busy falls on the cycle after dist_valid.
- All outputs are registered; there are no combinational paths from input to output.

## Configuration
- RANGER_FILTER_EN defined:
  - On a non-timeout DONE, dist_cm = (cm_cnt + last_good) >> 1, where last_good is the previous non-timeout raw cm_cnt. last_good then updates to cm_cnt.
  - The first sample after reset passes through raw.
  - Timeout samples bypass the filter and do not update last_good.
- RANGER_FILTER_EN undefined: dist_cm is the raw cm_cnt and no last_good register exists.

## Structure
- Package radar_pkg holds:
  - the ranger state enum: IDLE, TRIG, WAIT_HI, MEAS, DONE;
  - the shared constants CYCLES_PER_CM and MAX_CM, which the display stage also uses for scaling.
- One sub-module, echo_sync: a 2-flop synchronizer, reset to 0 on start.

## Test plan
- meas_req pulse:
  - trigger is high for exactly 1000 cycles.
  - Echo held high for 58000 cycles gives dist_valid once, dist_cm=10, dist_timeout=0, 3 cycles after the echo falls.
- Echo high for 5799 cycles gives dist_cm=0. Echo high for 5800 cycles gives dist_cm=1.
- Echo never rises: exactly WAIT_HI_CYCLES cycles after entering WAIT_HI, dist_valid=1, dist_cm=400, dist_timeout=1.
- Echo held high indefinitely: saturates, giving dist_cm=400 and dist_timeout=1 at 400×5800 echo cycles.
- start asserted at MEAS cycle 10000:
  - next edge gives state IDLE, trigger=0 and busy=0;
  - no dist_valid follows;
  - dist_cm keeps its old value.
- meas_req repeated while busy is ignored (one valid only).
- With RANGER_FILTER_EN defined, samples of 10 cm then 20 cm give outputs 10 then 15.
